// File: rtl/shift_add_mult_scheduler.sv
// rtl/shift_add_mult_scheduler.sv - round-robin shared shift-and-add unsigned multiplier
module shift_add_mult_scheduler #(
    parameter int M    = 8,
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*M-1:0]   a_flat,
    input  logic [NREQ*N-1:0]   b_flat,
    output logic [NREQ-1:0]     ack,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [IDW-1:0]      res_id,
    output logic [M+N-1:0]      result
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [M+N-1:0]   a1;
    logic [N-1:0]     b1;
    logic [M+N-1:0]   acc;
    logic [CW-1:0]    cnt;

    logic             found;
    logic [IDW-1:0]   gnt;
    logic [M+N-1:0]   pp;
    logic [M+N-1:0]   acc_nxt;

    // Round-robin pick: first pending requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt   = IDW'(idx);
            end
        end
    end

    // One partial product per RUN cycle: the shifted multiplicand when the current B bit is set.
    always_comb begin
        pp      = b1[cnt] ? (a1 << cnt) : '0;
        acc_nxt = acc + pp;
    end

    // Scheduler FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            a1        <= '0;
            b1        <= '0;
            acc       <= '0;
            cnt       <= '0;
            ack       <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            result    <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        a1     <= {{N{1'b0}}, a_flat[int'(gnt)*M +: M]};
                        b1     <= b_flat[int'(gnt)*N +: N];
                        acc    <= '0;
                        cnt    <= '0;
                        ack    <= {{(NREQ-1){1'b0}}, 1'b1} << gnt;
                        rr_ptr <= IDW'((int'(gnt) + 1) % NREQ);
                        res_id <= gnt;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    // Fixed N-cycle run; zero multiplier bits do not shorten it.
                    if (cnt == CW'(N - 1)) begin
                        result    <= acc_nxt;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_scheduler.sv
// tb/tb_shift_add_mult_scheduler.sv - directed and randomized checks of the shared multiplier scheduler
module tb_shift_add_mult_scheduler;

    localparam int M    = 8;
    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*M-1:0] a_flat = '0;
    logic [NREQ*N-1:0] b_flat = '0;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [IDW-1:0]    res_id;
    logic [M+N-1:0]    result;

    int nvec = 0;
    int errs = 0;

    shift_add_mult_scheduler #(.M(M), .N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .ack       (ack),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_rst;
        logic [3:0]  r;
        logic [1:0]  id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [1:0] id, input logic [7:0] v, input logic [7:0] decoy);
        logic [31:0] f;
        for (int i = 0; i < 4; i++) f[i*8 +: 8] = (i == int'(id)) ? v : decoy;
        return f;
    endfunction

    function automatic logic [1:0] first_from(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] g;
        logic       hit;
        g   = '0;
        hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (int'(ptr) + k) % 4;
            if (!hit && r[idx]) begin
                hit = 1'b1;
                g   = 2'(idx);
            end
        end
        return g;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic scramble_or_clear(input bit scramble);
        if (scramble) begin
            req    = 4'($urandom);
            a_flat = $urandom;
            b_flat = $urandom;
        end else begin
            req = '0;
        end
    endtask

    // One complete job: grant, N quiet RUN cycles, result, optional stall, handshake.
    task automatic run_job(input logic [3:0] r, input logic [31:0] af, input logic [31:0] bf,
                           input logic [1:0] eid, input logic [15:0] eres,
                           input int stall, input bit scramble);
        bit bad;
        @(negedge clk);
        req       = r;
        a_flat    = af;
        b_flat    = bf;
        res_ready = (stall == 0);
        @(posedge clk); #1;
        chk("ack_grant", 32'(ack), 32'(4'b1 << eid));
        chk("busy_grant", 32'(busy), 32'd1);
        chk("res_id_grant", 32'(res_id), 32'(eid));
        bad = 1'b0;
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            scramble_or_clear(scramble);
            @(posedge clk); #1;
            if (res_valid || ack != 4'b0 || !busy) bad = 1'b1;
        end
        chk("run_quiet", 32'(bad), 32'd0);
        @(negedge clk);
        scramble_or_clear(scramble);
        @(posedge clk); #1;
        chk("res_valid_rise", 32'(res_valid), 32'd1);
        chk("result", 32'(result), 32'(eres));
        chk("res_id", 32'(res_id), 32'(eid));
        bad = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            scramble_or_clear(scramble);
            @(posedge clk); #1;
            if (!res_valid || result != eres || res_id != eid || ack != 4'b0) bad = 1'b1;
        end
        if (stall > 0) chk("stall_hold", 32'(bad), 32'd0);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("res_valid_drop", 32'(res_valid), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
        chk("result_kept", 32'(result), 32'(eres));
    endtask

    initial begin
        bit         bad;
        logic [1:0] rr_m;

        tv[0]  = '{1'b0, 4'b0001, 2'd0,  8'd13,  8'd11, 16'd143};
        tv[1]  = '{1'b1, 4'b1111, 2'd0,  8'd5,   8'd7,  16'd35};
        tv[2]  = '{1'b0, 4'b1111, 2'd1,  8'd99,  8'd64, 16'd6336};
        tv[3]  = '{1'b0, 4'b1111, 2'd2,  8'd17, 8'd250, 16'd4250};
        tv[4]  = '{1'b0, 4'b1111, 2'd3,  8'd200, 8'd3,  16'd600};
        tv[5]  = '{1'b0, 4'b1001, 2'd0,  8'd5,   8'd7,  16'd35};
        tv[6]  = '{1'b0, 4'b1001, 2'd3,  8'd200, 8'd3,  16'd600};
        tv[7]  = '{1'b0, 4'b1001, 2'd0,  8'd5,   8'd7,  16'd35};
        tv[8]  = '{1'b0, 4'b0100, 2'd2,  8'd255, 8'd255, 16'hFE01};
        tv[9]  = '{1'b0, 4'b0010, 2'd1,  8'd0,  8'd200, 16'd0};
        tv[10] = '{1'b0, 4'b1000, 2'd3,  8'd77,  8'd0,  16'd0};
        tv[11] = '{1'b0, 4'b0001, 2'd0,  8'd1,  8'd128, 16'd128};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        rst = 1'b0;

        // Directed table: functional products, round-robin order, arithmetic corners
        for (int v = 0; v < 12; v++) begin
            if (tv[v].do_rst) pulse_reset();
            run_job(tv[v].r, lanes(tv[v].id, tv[v].a, 8'hA5), lanes(tv[v].id, tv[v].b, 8'h3C),
                    tv[v].id, tv[v].exp, 0, 1'b0);
        end

        // Backpressure in DONE with other requesters pending
        @(negedge clk);
        req       = 4'b0001;
        a_flat    = {8'd40, 8'd30, 8'd21, 8'd9};
        b_flat    = {8'd50, 8'd60, 8'd3, 8'd12};
        res_ready = 1'b0;
        @(posedge clk); #1;
        chk("bp_ack0", 32'(ack), 32'b0001);
        @(negedge clk);
        req = 4'b1110;
        bad = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            if (ack != 4'b0) bad = 1'b1;
        end
        chk("bp_run_noack", 32'(bad), 32'd0);
        chk("bp_valid", 32'(res_valid), 32'd1);
        chk("bp_result", 32'(result), 32'd108);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!res_valid || result != 16'd108 || res_id != 2'd0 || ack != 4'b0 || !busy) bad = 1'b1;
        end
        chk("bp_stall_stable", 32'(bad), 32'd0);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_valid", 32'(res_valid), 32'd0);
        chk("bp_hs_noack", 32'(ack), 32'd0);
        @(posedge clk); #1;
        chk("bp_next_ack", 32'(ack), 32'b0010);
        chk("bp_next_id", 32'(res_id), 32'd1);
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk);
        repeat (N - 1) @(posedge clk);
        #1;
        chk("bp_next_valid", 32'(res_valid), 32'd1);
        chk("bp_next_result", 32'(result), 32'd63);
        @(posedge clk); #1;
        chk("bp_next_drop", 32'(res_valid), 32'd0);

        // Reset in the middle of RUN
        @(negedge clk);
        req    = 4'b0001;
        a_flat = {8'd1, 8'd2, 8'd3, 8'd100};
        b_flat = {8'd1, 8'd2, 8'd3, 8'd100};
        @(posedge clk); #1;
        chk("abort_ack", 32'(ack), 32'b0001);
        @(negedge clk);
        req = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (res_valid || ack != 4'b0 || busy) bad = 1'b1;
        end
        chk("abort_silent", 32'(bad), 32'd0);
        run_job(4'b0100, lanes(2'd2, 8'd33, 8'hA5), lanes(2'd2, 8'd7, 8'h3C), 2'd2, 16'd231, 0, 1'b0);

        // Randomized scoreboard against a reference round-robin model
        pulse_reset();
        rr_m = 2'd0;
        for (int j = 0; j < 1500; j++) begin
            logic [3:0]  r;
            logic [31:0] af;
            logic [31:0] bf;
            logic [1:0]  g;
            logic [15:0] p;
            r  = 4'($urandom);
            if (r == 4'b0) r = 4'b1 << $urandom_range(0, 3);
            af = $urandom;
            bf = $urandom;
            g  = first_from(r, rr_m);
            rr_m = g + 2'd1;
            p  = 16'(af[int'(g)*8 +: 8]) * 16'(bf[int'(g)*8 +: 8]);
            run_job(r, af, bf, g, p, int'($urandom_range(0, 3)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
